// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 serial receiver with a small first-word-fall-through
// receive FIFO and sticky frame/overrun flags for CPU load access.
//
// state | meaning
// IDLE  | line idle, waiting for rxs to fall
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits LSB first at bit centres
// STOP  | sampling stop bit; push byte or flag framing error
// BRK   | line held low after bad stop; wait for release
module uart_rx_mmio #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          clr_err,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CW           = PW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_sync1;
    logic             r_rxs;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_stop_smp;
    logic w_push;
    logic w_ferr_set;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_ovr_set;

    // Stop-bit sample decides push versus framing error in the same edge.
    assign w_stop_smp = (r_state == STOP) && (r_cnt == BIT_LAST);
    assign w_push     = w_stop_smp && r_rxs;
    assign w_ferr_set = w_stop_smp && !r_rxs;
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = rd_en && (r_count != '0);
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_ovr_set  = w_push && w_full && !w_pop;

    assign rd_data   = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
    assign rx_valid  = (r_count != '0);
    assign rx_count  = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Two-flop synchroniser for the asynchronous line input.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_rxs   <= r_sync1;
        end
    end

    // Receive FSM: bit timing, sampling and shift register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rxs) r_state <= START;
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_state <= r_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rxs;
                        if (r_idx == 3'd7) r_state <= STOP;
                        else               r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rxs ? IDLE : BRK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BRK: begin
                    r_cnt <= '0;
                    if (r_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility.
    always_ff @(posedge sys_clk_i) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
        end
    end

    // Sticky error flags; a set event outranks a same-cycle clear.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set)   r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
            if (w_ovr_set)    r_overrun   <= 1'b1;
            else if (clr_err) r_overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_mmio;

    localparam int CLK_FREQ   = 16;
    localparam int BAUD       = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    uart_rx_mmio #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .uart_rx   (uart_rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .clr_err   (clr_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        tick(CPB);
    endtask

    // Start and data bits only; caller handles the stop bit.
    task automatic drive_head(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    // Full frame; the stop sample lands on the 11th edge of the stop bit.
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic pop_at_sample);
        drive_head(d);
        uart_rx = stop;
        tick(10);
        if (pop_at_sample) begin
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(5);
        end else begin
            tick(6);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] batch1 [4];
        logic [7:0] batch2 [4];
        logic [7:0] fill   [4];
        batch1 = '{8'h01, 8'h02, 8'h03, 8'h04};
        batch2 = '{8'h10, 8'h11, 8'h12, 8'h13};
        fill   = '{8'h21, 8'h22, 8'h23, 8'h24};

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_count", {29'd0, rx_count}, 32'd0);
        check("rst_data",  {24'd0, rd_data}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("rst_ovr",   {31'd0, overrun}, 32'd0);

        // Single frame with exact push timing.
        drive_head(8'hA5);
        uart_rx = 1'b1;
        tick(10);
        check("single_pre_valid", {31'd0, rx_valid}, 32'd0);
        tick(1);
        check("single_valid", {31'd0, rx_valid}, 32'd1);
        check("single_count", {29'd0, rx_count}, 32'd1);
        check("single_ferr",  {31'd0, frame_err}, 32'd0);
        check("single_ovr",   {31'd0, overrun}, 32'd0);
        tick(5);
        pop_check("single_data", 8'hA5);
        check("single_empty_valid", {31'd0, rx_valid}, 32'd0);
        check("single_empty_data",  {24'd0, rd_data}, 32'd0);

        // Back-to-back frames, two batches to wrap the pointers.
        for (int i = 0; i < 4; i++) send_byte(batch1[i], 1'b1, 1'b0);
        check("b2b1_count", {29'd0, rx_count}, 32'd4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("b2b1_data%0d", i), batch1[i]);
        for (int i = 0; i < 4; i++) send_byte(batch2[i], 1'b1, 1'b0);
        check("b2b2_count", {29'd0, rx_count}, 32'd4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("b2b2_data%0d", i), batch2[i]);
        check("b2b2_empty", {31'd0, rx_valid}, 32'd0);

        // Overrun: full FIFO, no read on push.
        for (int i = 0; i < 4; i++) send_byte(fill[i], 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check("ovr_flag",  {31'd0, overrun}, 32'd1);
        check("ovr_count", {29'd0, rx_count}, 32'd4);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_data%0d", i), fill[i]);
        pulse_clr();
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Full FIFO with a pop on the push cycle: byte accepted.
        for (int i = 0; i < 4; i++) send_byte(fill[i], 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b1);
        check("ovrpop_flag",  {31'd0, overrun}, 32'd0);
        check("ovrpop_count", {29'd0, rx_count}, 32'd4);
        for (int i = 1; i < 4; i++) pop_check($sformatf("ovrpop_data%0d", i), fill[i]);
        pop_check("ovrpop_data55", 8'h55);

        // Framing error followed by a held break.
        send_byte(8'h3C, 1'b0, 1'b0);
        tick(40);
        check("frm_flag",  {31'd0, frame_err}, 32'd1);
        check("frm_count", {29'd0, rx_count}, 32'd0);
        uart_rx = 1'b1;
        tick(20);
        check("brk_count", {29'd0, rx_count}, 32'd0);
        send_byte(8'h7E, 1'b1, 1'b0);
        check("frm_sticky", {31'd0, frame_err}, 32'd1);
        check("frm_count2", {29'd0, rx_count}, 32'd1);
        pop_check("frm_data", 8'h7E);
        pulse_clr();
        check("frm_cleared", {31'd0, frame_err}, 32'd0);

        // Short low glitch must not start a frame.
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(30);
        check("glitch_count", {29'd0, rx_count}, 32'd0);
        check("glitch_ferr",  {31'd0, frame_err}, 32'd0);
        check("glitch_ovr",   {31'd0, overrun}, 32'd0);
        send_byte(8'h5A, 1'b1, 1'b0);
        pop_check("glitch_after", 8'h5A);

        // Reset mid-frame with a flag set and two bytes buffered.
        send_byte(8'h00, 1'b0, 1'b0);
        uart_rx = 1'b1;
        tick(20);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        check("pre_rst_count", {29'd0, rx_count}, 32'd2);
        check("pre_rst_ferr",  {31'd0, frame_err}, 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        uart_rx = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_count", {29'd0, rx_count}, 32'd0);
        check("mrst_valid", {31'd0, rx_valid}, 32'd0);
        check("mrst_data",  {24'd0, rd_data}, 32'd0);
        check("mrst_ferr",  {31'd0, frame_err}, 32'd0);
        tick(7);
        for (int i = 4; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        tick(20);
        check("mrst_no_byte", {29'd0, rx_count}, 32'd0);
        send_byte(8'h42, 1'b1, 1'b0);
        check("mrst_after_count", {29'd0, rx_count}, 32'd1);
        pop_check("mrst_after_data", 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
